// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG user data-register channel.
// The constants give the bit layout of the TDO capture word.
package jtag_pkg;

  localparam int OUT_FLAG_DONE  = 0;
  localparam int OUT_FLAG_OVF   = 1;
  localparam int OUT_RESULT_LSB = 2;
  localparam int OUT_FLAG_BITS  = 2;

  // Status flags in the low bits of the capture word.
  // Declaration order puts done at bit 0 and ovf at bit 1.
  typedef struct packed {
    logic ovf;
    logic done;
  } out_flags_t;

endpackage

// File: rtl/jtag_dr_channel_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic                  do_push, do_pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Gate the head word so the output stays zero while nothing is buffered.
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/jtag_dr_channel.sv
// JTAG user data-register engine: deserialises TDI into buffered words and
// serialises a captured result plus status flags back out on TDO.
module jtag_dr_channel
  import jtag_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int RESULT_WIDTH = 32
) (
  input  logic                    tck,
  input  logic                    rst_n,
  input  logic                    tdi,
  output logic                    tdo,
  input  logic                    ir_is_user,
  input  logic                    capture_dr,
  input  logic                    shift_dr,
  input  logic                    update_dr,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    eos,
  input  logic [RESULT_WIDTH-1:0] result,
  input  logic                    result_valid,
  output logic                    overflow
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam int OUT_W = RESULT_WIDTH + OUT_FLAG_BITS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef struct packed {
    logic [RESULT_WIDTH-1:0] result;
    out_flags_t              flags;
  } out_reg_t;

  logic                    user_shift, user_capture, user_update;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    push_valid_q, push_valid_d;
  logic [DATA_WIDTH-1:0]   push_data_q, push_data_d;
  logic                    eos_q, eos_d;
  logic                    overflow_q, overflow_d;
  logic [RESULT_WIDTH-1:0] hold_q, hold_d;
  logic                    done_q, done_d;
  logic [OUT_W-1:0]        out_q, out_d;
  out_reg_t                cap_word;
  logic                    fifo_full, fifo_empty, fifo_pop;

  assign user_shift   = ir_is_user & shift_dr;
  assign user_capture = ir_is_user & capture_dr;
  assign user_update  = ir_is_user & update_dr;

  assign fifo_pop = ~fifo_empty & m_ready;
  assign m_valid  = ~fifo_empty;
  assign eos      = eos_q;
  assign overflow = overflow_q;
  assign tdo      = out_q[OUT_FLAG_DONE];

  // Deserialiser: LSB-first, completed word goes to the push register.
  always_comb begin
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    push_valid_d = 1'b0;
    push_data_d  = push_data_q;
    eos_d        = 1'b0;
    if (user_shift) begin
      shift_d = {tdi, shift_q[DATA_WIDTH-1:1]};
      if (cnt_q == CNT_LAST) begin
        push_valid_d = 1'b1;
        push_data_d  = {tdi, shift_q[DATA_WIDTH-1:1]};
        cnt_d        = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Update-DR drops any partial word; a word completed this cycle is kept.
    if (user_update) begin
      shift_d = '0;
      cnt_d   = '0;
      eos_d   = 1'b1;
    end
  end

  // Sticky overflow: the push register held a word the FIFO could not take.
  assign overflow_d = overflow_q | (push_valid_q & fifo_full & ~fifo_pop);

  always_comb begin
    hold_d = hold_q;
    done_d = done_q;
    if (result_valid) begin
      hold_d = result;
      done_d = 1'b1;
    end
  end

  always_comb begin
    cap_word.result     = hold_q;
    cap_word.flags.ovf  = overflow_q;
    cap_word.flags.done = done_q;
  end

  // Capture takes priority over shift if both are ever asserted.
  always_comb begin
    out_d = out_q;
    if (user_capture) begin
      out_d = cap_word;
    end else if (user_shift) begin
      out_d = {tdi, out_q[OUT_W-1:1]};
    end
  end

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      shift_q      <= '0;
      cnt_q        <= '0;
      push_valid_q <= 1'b0;
      push_data_q  <= '0;
      eos_q        <= 1'b0;
      overflow_q   <= 1'b0;
      hold_q       <= '0;
      done_q       <= 1'b0;
      out_q        <= '0;
    end else begin
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      push_valid_q <= push_valid_d;
      push_data_q  <= push_data_d;
      eos_q        <= eos_d;
      overflow_q   <= overflow_d;
      hold_q       <= hold_d;
      done_q       <= done_d;
      out_q        <= out_d;
    end
  end

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (tck),
    .rst_n     (rst_n),
    .push      (push_valid_q),
    .push_data (push_data_q),
    .pop       (m_ready),
    .pop_data  (m_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_jtag_dr_channel.sv
// Scoreboard bench for jtag_dr_channel: stimulus queues expected words and
// TDO bits, a negedge monitor pops and compares them as the DUT presents them.
module tb_jtag_dr_channel;

  logic        tck = 1'b0;
  logic        rst_n = 1'b0;
  logic        tdi = 1'b0;
  logic        tdo;
  logic        ir_is_user = 1'b0;
  logic        capture_dr = 1'b0;
  logic        shift_dr = 1'b0;
  logic        update_dr = 1'b0;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        eos;
  logic [31:0] result = '0;
  logic        result_valid = 1'b0;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;
  int eos_cnt = 0;
  int eos_exp = 0;
  logic tdo_chk = 1'b0;
  logic [7:0] exp_q[$];
  logic       tdo_q[$];

  always #5 tck = ~tck;

  jtag_dr_channel #(
    .DATA_WIDTH   (8),
    .FIFO_DEPTH   (16),
    .RESULT_WIDTH (32)
  ) dut (
    .tck          (tck),
    .rst_n        (rst_n),
    .tdi          (tdi),
    .tdo          (tdo),
    .ir_is_user   (ir_is_user),
    .capture_dr   (capture_dr),
    .shift_dr     (shift_dr),
    .update_dr    (update_dr),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .eos          (eos),
    .result       (result),
    .result_valid (result_valid),
    .overflow     (overflow)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endfunction

  // Monitor: handshakes and TDO bits are sampled on the falling edge.
  always @(negedge tck) begin
    if (rst_n) begin
      if (eos) eos_cnt++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got %0h, expected none", m_data);
        end else begin
          check("m_data", {56'd0, m_data}, {56'd0, exp_q.pop_front()});
        end
      end
      if (tdo_chk && ir_is_user && shift_dr) begin
        if (tdo_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL tdo_extra: got %0b, expected none", tdo);
        end else begin
          check("tdo_bit", {63'd0, tdo}, {63'd0, tdo_q.pop_front()});
        end
      end
    end
  end

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic shift_bits(input logic [63:0] val, input int n, input logic ir);
    for (int i = 0; i < n; i++) begin
      ir_is_user = ir;
      shift_dr   = 1'b1;
      tdi        = val[i];
      tick();
    end
    shift_dr   = 1'b0;
    tdi        = 1'b0;
    ir_is_user = 1'b1;
  endtask

  task automatic do_update();
    ir_is_user = 1'b1;
    update_dr  = 1'b1;
    tick();
    update_dr  = 1'b0;
    eos_exp++;
  endtask

  task automatic do_capture();
    ir_is_user = 1'b1;
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      tick();
      k++;
    end
    check(name, exp_q.size(), 0);
    repeat (4) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_valid"},  {63'd0, m_valid},  0);
    check({tag, "_m_data"},   {56'd0, m_data},   0);
    check({tag, "_eos"},      {63'd0, eos},      0);
    check({tag, "_overflow"}, {63'd0, overflow}, 0);
    check({tag, "_tdo"},      {63'd0, tdo},      0);
  endtask

  initial begin
    logic [33:0] cap;
    logic [41:0] pat;

    #12;
    check_reset_outputs("reset");
    @(posedge tck);
    #1;
    rst_n      = 1'b1;
    ir_is_user = 1'b1;
    tick();

    // Three words, eos once, no overflow.
    m_ready = 1'b1;
    eos_cnt = 0;
    eos_exp = 0;
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h32);
    exp_q.push_back(8'h0A);
    shift_bits(64'h0A3231, 24, 1'b1);
    do_update();
    wait_drain("t1_drain");
    check("t1_eos_count", eos_cnt, 1);
    check("t1_overflow", {63'd0, overflow}, 0);

    // Partial word discarded on update, counter restarts.
    exp_q.push_back(8'hA5);
    shift_bits(64'h3A5, 12, 1'b1);
    do_update();
    exp_q.push_back(8'h5A);
    shift_bits(64'h5A, 8, 1'b1);
    wait_drain("t2_drain");
    check("t2_eos_count", eos_cnt, eos_exp);

    // Fill to 16, 17th word dropped and flagged.
    m_ready = 1'b0;
    for (int w = 0; w < 16; w++) begin
      exp_q.push_back(8'(w));
      shift_bits(64'(w), 8, 1'b1);
    end
    repeat (3) tick();
    check("t3_overflow_at_16", {63'd0, overflow}, 0);
    check("t3_m_valid_full", {63'd0, m_valid}, 1);
    shift_bits(64'h10, 8, 1'b1);
    repeat (3) tick();
    check("t3_overflow_at_17", {63'd0, overflow}, 1);
    m_ready = 1'b1;
    wait_drain("t3_drain");
    check("t3_overflow_sticky", {63'd0, overflow}, 1);

    // Asynchronous reset mid-word with buffered words.
    m_ready = 1'b0;
    shift_bits(64'hEEDD, 16, 1'b1);
    shift_bits(64'h5, 3, 1'b1);
    repeat (3) tick();
    check("t6_m_valid_pre_reset", {63'd0, m_valid}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge tck);
    #1;
    rst_n   = 1'b1;
    m_ready = 1'b1;
    exp_q.push_back(8'h66);
    shift_bits(64'h66, 8, 1'b1);
    wait_drain("t6_post_reset_word");

    // Full FIFO with a push landing in the same cycle as a pop.
    m_ready = 1'b0;
    for (int w = 0; w < 16; w++) begin
      exp_q.push_back(8'(8'h20 + w));
      shift_bits(64'(8'h20 + w), 8, 1'b1);
    end
    repeat (3) tick();
    exp_q.push_back(8'h30);
    shift_bits(64'h30, 7, 1'b1);
    ir_is_user = 1'b1;
    shift_dr   = 1'b1;
    tdi        = 1'b0;
    tick();
    shift_dr   = 1'b0;
    m_ready    = 1'b1;
    tick();
    m_ready    = 1'b0;
    repeat (3) tick();
    check("t4_overflow_simul_pop", {63'd0, overflow}, 0);
    m_ready = 1'b1;
    wait_drain("t4_drain");

    // Result capture and serial readback with loopback of tdi.
    result       = 32'hDEADBEEF;
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    result       = 32'h0;
    do_capture();
    check("t5_tdo_after_capture", {63'd0, tdo}, 1);
    cap = {32'hDEADBEEF, 1'b0, 1'b1};
    pat = {2'b10, 40'h5544332211};
    for (int i = 0; i < 34; i++) tdo_q.push_back(cap[i]);
    for (int i = 0; i < 8; i++)  tdo_q.push_back(pat[i]);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h55);
    tdo_chk = 1'b1;
    shift_bits(64'(pat), 42, 1'b1);
    tdo_chk = 1'b0;
    check("t5_tdo_all_seen", tdo_q.size(), 0);
    do_update();
    wait_drain("t5_drain");

    // Inputs ignored while ir_is_user is low.
    do_capture();
    eos_cnt = 0;
    eos_exp = 0;
    shift_bits(64'hFF, 8, 1'b0);
    ir_is_user = 1'b0;
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
    update_dr  = 1'b1;
    tick();
    update_dr  = 1'b0;
    ir_is_user = 1'b1;
    repeat (4) tick();
    check("t6_no_eos", eos_cnt, 0);
    check("t6_no_word", {63'd0, m_valid}, 0);
    for (int i = 0; i < 34; i++) tdo_q.push_back(cap[i]);
    for (int i = 0; i < 4; i++)  exp_q.push_back(8'h00);
    tdo_chk = 1'b1;
    shift_bits(64'h0, 34, 1'b1);
    tdo_chk = 1'b0;
    check("t6_tdo_all_seen", tdo_q.size(), 0);
    do_update();
    wait_drain("t6_drain");
    check("t6_eos_count", eos_cnt, eos_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
